// File: rtl/irrigation_cycle_controller.sv
// Timed irrigation sequencer: sprinkler/drip bursts separated by soak pauses,
// reservoir inlet hysteresis, and lockout on sensor error or repeated dry cycles.
module irrigation_cycle_controller #(
    parameter int SPRINKLE_TICKS = 30,
    parameter int DRIP_TICKS     = 60,
    parameter int SOAK_TICKS     = 20,
    parameter int MAX_CYCLES     = 4,
    parameter int TIMER_W        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       high,
    input  logic       middle,
    input  logic       low,
    input  logic       umidadeDoSolo,
    input  logic       umidadeDoAr,
    input  logic       erro,
    input  logic       ack,
    output logic       ValvulaDeAspersao,
    output logic       ValvulaDeGotejamento,
    output logic       ValvulaDeEntrada,
    output logic       saidaDoAlarme,
    output logic       fault_cycles,
    output logic [2:0] estado
);

    localparam int CNT_W = $clog2(MAX_CYCLES + 2);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPRINKLE = 3'd1,
        DRIP     = 3'd2,
        SOAK     = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [CNT_W-1:0]   cycle_count_reg, cycle_count_next;
    logic               fault_reg, fault_next;
    logic               asp_reg, gota_reg, entrada_reg, alarme_reg;

    logic               demand;
    logic               expire;
    state_t             burst_state;
    logic [TIMER_W-1:0] burst_len;
    logic [CNT_W-1:0]   count_inc;

    assign demand      = ~umidadeDoSolo & low & ~erro;
    // timer_reg <= 1 rather than == 1 so a zero timer can never wrap
    assign expire      = tick && (timer_reg <= TIMER_W'(1));
    assign burst_state = (~umidadeDoAr & middle) ? SPRINKLE : DRIP;
    assign burst_len   = (~umidadeDoAr & middle) ? TIMER_W'(SPRINKLE_TICKS) : TIMER_W'(DRIP_TICKS);
    assign count_inc   = (cycle_count_reg == {CNT_W{1'b1}}) ? cycle_count_reg : cycle_count_reg + 1'b1;

    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        cycle_count_next = cycle_count_reg;
        fault_next       = fault_reg;
        case (state_reg)
            IDLE: begin
                if (erro) begin
                    state_next = LOCKOUT;
                end else if (umidadeDoSolo) begin
                    cycle_count_next = '0;
                end else if (demand) begin
                    state_next       = burst_state;
                    timer_next       = burst_len;
                    cycle_count_next = count_inc;
                end
            end
            SPRINKLE, DRIP: begin
                if (erro) begin
                    state_next = LOCKOUT;
                    timer_next = '0;
                end else if (umidadeDoSolo) begin
                    state_next       = IDLE;
                    timer_next       = '0;
                    cycle_count_next = '0;
                end else if (!low) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (expire) begin
                    state_next = SOAK;
                    timer_next = TIMER_W'(SOAK_TICKS);
                end else if (tick) begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            SOAK: begin
                if (erro) begin
                    state_next = LOCKOUT;
                    timer_next = '0;
                end else if (umidadeDoSolo) begin
                    state_next       = IDLE;
                    timer_next       = '0;
                    cycle_count_next = '0;
                end else if (expire) begin
                    if (demand && (cycle_count_reg >= CNT_W'(MAX_CYCLES))) begin
                        state_next = LOCKOUT;
                        timer_next = '0;
                        fault_next = 1'b1;
                    end else if (demand) begin
                        state_next       = burst_state;
                        timer_next       = burst_len;
                        cycle_count_next = count_inc;
                    end else begin
                        state_next = IDLE;
                        timer_next = '0;
                    end
                end else if (tick) begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            LOCKOUT: begin
                if (ack && !erro) begin
                    state_next       = IDLE;
                    cycle_count_next = '0;
                    fault_next       = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state so they line up with state_reg.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            cycle_count_reg <= '0;
            fault_reg       <= 1'b0;
            asp_reg         <= 1'b0;
            gota_reg        <= 1'b0;
            entrada_reg     <= 1'b0;
            alarme_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            cycle_count_reg <= cycle_count_next;
            fault_reg       <= fault_next;
            asp_reg         <= (state_next == SPRINKLE);
            gota_reg        <= (state_next == DRIP);
            alarme_reg      <= ~low | erro | (state_next == LOCKOUT);
            if (high || erro) begin
                entrada_reg <= 1'b0;
            end else if (!middle) begin
                entrada_reg <= 1'b1;
            end
        end
    end

    assign ValvulaDeAspersao    = asp_reg;
    assign ValvulaDeGotejamento = gota_reg;
    assign ValvulaDeEntrada     = entrada_reg;
    assign saidaDoAlarme        = alarme_reg;
    assign fault_cycles         = fault_reg;
    assign estado               = state_reg;

endmodule

// File: tb/tb_irrigation_cycle_controller.sv
// Directed bench for irrigation_cycle_controller: burst timing, lockout, inlet hysteresis, reset.
module tb_irrigation_cycle_controller;

    logic       clock = 1'b0;
    logic       reset, tick, high, middle, low, umidadeDoSolo, umidadeDoAr, erro, ack;
    logic       ValvulaDeAspersao, ValvulaDeGotejamento, ValvulaDeEntrada, saidaDoAlarme;
    logic       fault_cycles;
    logic [2:0] estado;

    int vectors    = 0;
    int miscompares = 0;

    irrigation_cycle_controller dut (
        .clock                (clock),
        .reset                (reset),
        .tick                 (tick),
        .high                 (high),
        .middle               (middle),
        .low                  (low),
        .umidadeDoSolo        (umidadeDoSolo),
        .umidadeDoAr          (umidadeDoAr),
        .erro                 (erro),
        .ack                  (ack),
        .ValvulaDeAspersao    (ValvulaDeAspersao),
        .ValvulaDeGotejamento (ValvulaDeGotejamento),
        .ValvulaDeEntrada     (ValvulaDeEntrada),
        .saidaDoAlarme        (saidaDoAlarme),
        .fault_cycles         (fault_cycles),
        .estado               (estado)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
        $display("vector %0d %s: observed %0d expected %0d", vectors, tag, observed, expected);
    endtask

    // One tick pulse followed by an idle cycle; sampled after each edge.
    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    // Count tick pulses spent in state st; flags any cycle where the valves disagree with the state.
    task automatic count_ticks(input logic [2:0] st, output int n, output int bad);
        n   = 0;
        bad = 0;
        while (estado == st && n < 200) begin
            if (ValvulaDeAspersao !== (st == 3'd1) || ValvulaDeGotejamento !== (st == 3'd2))
                bad++;
            pulse_tick();
            n++;
        end
    endtask

    initial begin
        int n, bad;
        reset = 1'b1; tick = 1'b0; high = 1'b0; middle = 1'b1; low = 1'b1;
        umidadeDoSolo = 1'b0; umidadeDoAr = 1'b0; erro = 1'b0; ack = 1'b0;
        step();
        step();
        check("reset_estado", estado, 0);
        check("reset_outputs", {ValvulaDeAspersao, ValvulaDeGotejamento, ValvulaDeEntrada,
                                saidaDoAlarme, fault_cycles}, 0);

        // Sprinkler burst of 30 ticks then 20-tick soak, four times, then lockout.
        reset = 1'b0;
        step();
        check("sprinkle_entry_estado", estado, 1);
        check("sprinkle_entry_valves", {ValvulaDeAspersao, ValvulaDeGotejamento}, 2);
        for (int b = 1; b <= 4; b++) begin
            count_ticks(3'd1, n, bad);
            check($sformatf("burst%0d_ticks", b), n, 30);
            check($sformatf("burst%0d_valves", b), bad, 0);
            check($sformatf("burst%0d_to_soak", b), estado, 3);
            count_ticks(3'd3, n, bad);
            check($sformatf("soak%0d_ticks", b), n, 20);
            check($sformatf("soak%0d_valves", b), bad, 0);
            check($sformatf("soak%0d_next", b), estado, (b == 4) ? 4 : 1);
        end
        check("lockout_fault", fault_cycles, 1);
        check("lockout_alarm", saidaDoAlarme, 1);
        check("lockout_valves", {ValvulaDeAspersao, ValvulaDeGotejamento}, 0);
        pulse_tick();
        check("lockout_holds", estado, 4);
        umidadeDoSolo = 1'b1; ack = 1'b1;
        step();
        ack = 1'b0;
        check("ack_exit_estado", estado, 0);
        check("ack_exit_fault", fault_cycles, 0);

        // Drip burst when air is humid: 60 ticks, sprinkler never on.
        umidadeDoSolo = 1'b0; umidadeDoAr = 1'b1;
        step();
        check("drip_entry_estado", estado, 2);
        check("drip_entry_valves", {ValvulaDeAspersao, ValvulaDeGotejamento}, 1);
        count_ticks(3'd2, n, bad);
        check("drip_ticks", n, 60);
        check("drip_valves", bad, 0);
        check("drip_to_soak", estado, 3);

        // Soil wet during soak returns to idle.
        umidadeDoSolo = 1'b1;
        step();
        check("soak_wet_idle", estado, 0);

        // Reset asserted mid-drip with 17 ticks remaining.
        umidadeDoSolo = 1'b0;
        step();
        for (int i = 0; i < 43; i++) pulse_tick();
        check("drip_midway_estado", estado, 2);
        umidadeDoSolo = 1'b1; reset = 1'b1;
        step();
        check("reset_mid_drip_estado", estado, 0);
        check("reset_mid_drip_outputs", {ValvulaDeAspersao, ValvulaDeGotejamento, ValvulaDeEntrada,
                                         saidaDoAlarme, fault_cycles}, 0);
        reset = 1'b0;

        // Error beats soil-wet mid-sprinkle; ack ignored while error persists.
        umidadeDoSolo = 1'b0; umidadeDoAr = 1'b0;
        step();
        check("sprinkle2_entry", estado, 1);
        for (int i = 0; i < 5; i++) pulse_tick();
        erro = 1'b1; umidadeDoSolo = 1'b1;
        step();
        check("erro_over_wet_estado", estado, 4);
        check("erro_valves", {ValvulaDeAspersao, ValvulaDeGotejamento}, 0);
        check("erro_alarm", saidaDoAlarme, 1);
        check("erro_fault_cycles", fault_cycles, 0);
        ack = 1'b1;
        step();
        check("ack_with_erro", estado, 4);
        erro = 1'b0;
        step();
        ack = 1'b0;
        check("ack_clear", estado, 0);

        // Losing the low sensor mid-burst returns to idle and raises the alarm.
        umidadeDoSolo = 1'b0;
        step();
        check("sprinkle3_entry", estado, 1);
        low = 1'b0;
        step();
        check("low_lost_estado", estado, 0);
        check("low_lost_alarm", saidaDoAlarme, 1);
        low = 1'b1; umidadeDoSolo = 1'b1;
        step();
        check("alarm_clears", saidaDoAlarme, 0);

        // Inlet hysteresis between middle and high.
        middle = 1'b0; high = 1'b0;
        step();
        check("inlet_set", ValvulaDeEntrada, 1);
        middle = 1'b1;
        step();
        check("inlet_hold", ValvulaDeEntrada, 1);
        high = 1'b1;
        step();
        check("inlet_clear_high", ValvulaDeEntrada, 0);
        high = 1'b0; middle = 1'b0; erro = 1'b1;
        step();
        check("inlet_blocked_erro", ValvulaDeEntrada, 0);
        high = 1'b1; middle = 1'b0; erro = 1'b0;
        step();
        check("inlet_clear_wins", ValvulaDeEntrada, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
